// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// regfile : 32 x 32 register file with two combinational read ports, one
//           synchronous write port, hardwired $0 and write-to-read bypass.
// Rev 1.0
// ============================================================================
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NUM_RPORTS = 2;

  // Register 0 has no storage; it reads back as a constant zero.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (waddr == ADDR_W'(i)) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  logic [NUM_RPORTS-1:0] re_vec;
  logic [ADDR_W-1:0]     raddr_vec [NUM_RPORTS];

  assign re_vec       = {re2, re1};
  assign raddr_vec[0] = raddr1;
  assign raddr_vec[1] = raddr2;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] data;

    // Decoded mux over the populated registers; index 0 never matches.
    always_comb begin
      stored = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (raddr_vec[p] == ADDR_W'(i)) begin
          stored = regs[i];
        end
      end
    end

    // Bypass sits below the zero/enable checks so $0 and disabled ports stay 0.
    always_comb begin
      data = '0;
      if (!rst) begin
        data = '0;
      end else if (raddr_vec[p] == '0) begin
        data = '0;
      end else if (!re_vec[p]) begin
        data = '0;
      end else if (we && (waddr == raddr_vec[p])) begin
        data = wdata;
      end else begin
        data = stored;
      end
    end
  end

  assign rdata1 = g_rport[0].data;
  assign rdata2 = g_rport[1].data;

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// tb_regfile : scoreboard bench for regfile (directed plan plus random mix).
// Rev 1.0
// ============================================================================
module tb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] waddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              re1 = 1'b0;
  logic [ADDR_W-1:0] raddr1 = '0;
  logic [DATA_W-1:0] rdata1;
  logic              re2 = 1'b0;
  logic [ADDR_W-1:0] raddr2 = '0;
  logic [DATA_W-1:0] rdata2;

  int total = 0;
  int bad = 0;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e2;
  } exp_t;

  exp_t sbq[$];

  logic [DATA_W-1:0] mdl [0:NUM_REGS-1];

  regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  // Reference storage follows the architectural write rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mdl[i] <= '0;
    end else if (we && waddr != '0) begin
      mdl[waddr] <= wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                           input logic [DATA_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input logic [DATA_W-1:0] e1,
                           input logic [DATA_W-1:0] e2);
    exp_t e;
    e.tag = tag;
    e.e1  = e1;
    e.e2  = e2;
    sbq.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: got empty queue want pending entry");
    end else begin
      e = sbq.pop_front();
      check_val({e.tag, "/p1"}, rdata1, e.e1);
      check_val({e.tag, "/p2"}, rdata2, e.e2);
    end
  endtask

  task automatic drive(input logic w, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic r1,
                       input logic [ADDR_W-1:0] a1, input logic r2,
                       input logic [ADDR_W-1:0] a2);
    we = w; waddr = wa; wdata = wd;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  // One cycle: drive just after the edge, check mid-cycle, write commits at next edge.
  task automatic step(input string tag, input logic w, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd, input logic r1,
                      input logic [ADDR_W-1:0] a1, input logic r2,
                      input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] e1,
                      input logic [DATA_W-1:0] e2);
    @(posedge clk);
    #1;
    drive(w, wa, wd, r1, a1, r2, a2);
    expect_rd(tag, e1, e2);
    #3;
    sample();
  endtask

  function automatic logic [DATA_W-1:0] model_rd(input logic r, input logic [ADDR_W-1:0] a);
    if (!rst)                 return '0;
    if (a == '0)              return '0;
    if (!r)                   return '0;
    if (we && waddr == a)     return wdata;
    return mdl[a];
  endfunction

  initial begin
    // Reset state: outputs forced low even with reads and a write requested.
    drive(1'b1, 5'd4, 32'hCAFE_0004, 1'b1, 5'd4, 1'b1, 5'd4);
    #2;
    expect_rd("reset_state", 32'h0, 32'h0);
    sample();
    @(posedge clk); #1;
    rst = 1'b1;

    // Test 1: fill all registers, checking bypass on p1 and storage on p2.
    for (int i = 1; i < NUM_REGS; i++) begin
      step("fill", 1'b1, ADDR_W'(i), 32'hA5A5_0000 + i, 1'b1, ADDR_W'(i), 1'b1,
           ADDR_W'(i - 1), 32'hA5A5_0000 + i, (i == 1) ? 32'h0 : 32'hA5A5_0000 + i - 1);
    end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 1; i < NUM_REGS; i++) begin
      step("after_reset", 1'b0, '0, '0, 1'b1, ADDR_W'(i), 1'b1, ADDR_W'(NUM_REGS - i),
           32'h0, 32'h0);
    end

    // Test 2: write then read on both ports, then disable port 1.
    step("wr_r7",   1'b1, 5'd7,  32'h1234_5678, 1'b0, 5'd7, 1'b0, 5'd31, 32'h0, 32'h0);
    step("wr_r31",  1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1, 5'd7, 1'b1, 5'd31,
         32'h1234_5678, 32'hDEAD_BEEF);
    step("rd_both", 1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd31, 32'h1234_5678, 32'hDEAD_BEEF);
    step("re1_off", 1'b0, '0, '0, 1'b0, 5'd7, 1'b1, 5'd31, 32'h0, 32'hDEAD_BEEF);

    // Test 3: register zero ignores writes and bypass.
    step("r0_wr",   1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0);
    step("r0_next", 1'b0, '0, '0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0);

    // Test 4: same-cycle bypass over an older value.
    step("r5_init",  1'b1, 5'd5, 32'h0000_0001, 1'b0, '0, 1'b0, '0, 32'h0, 32'h0);
    step("r5_byp",   1'b1, 5'd5, 32'h0000_0002, 1'b1, 5'd5, 1'b1, 5'd5,
         32'h0000_0002, 32'h0000_0002);
    step("r5_store", 1'b0, '0, '0, 1'b1, 5'd5, 1'b1, 5'd5, 32'h0000_0002, 32'h0000_0002);

    // Test 5: bypass stays on its own address.
    step("r10_init", 1'b1, 5'd10, 32'h0000_0010, 1'b0, '0, 1'b0, '0, 32'h0, 32'h0);
    step("no_leak",  1'b1, 5'd9,  32'h0000_0099, 1'b1, 5'd10, 1'b1, 5'd9,
         32'h0000_0010, 32'h0000_0099);
    step("no_leak2", 1'b0, '0, '0, 1'b1, 5'd9, 1'b1, 5'd10, 32'h0000_0099, 32'h0000_0010);

    // Test 6: asynchronous reset between edges with a write pending.
    step("r3_init", 1'b1, 5'd3, 32'h0000_0077, 1'b0, '0, 1'b0, '0, 32'h0, 32'h0);
    step("r3_byp",  1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd3, 1'b1, 5'd3,
         32'h0000_0033, 32'h0000_0033);
    #1;
    rst = 1'b0;
    #1;
    expect_rd("async_rst", 32'h0, 32'h0);
    sample();
    @(posedge clk); #1;
    expect_rd("rst_hold", 32'h0, 32'h0);
    sample();
    drive(1'b0, '0, '0, 1'b1, 5'd3, 1'b1, 5'd3);
    rst = 1'b1;
    #2;
    expect_rd("r3_cleared", 32'h0, 32'h0);
    sample();
    step("r3_cleared2", 1'b0, '0, '0, 1'b1, 5'd3, 1'b1, 5'd3, 32'h0, 32'h0);

    // Random mix on a narrow address window to hit bypass and $0 often.
    for (int n = 0; n < 300; n++) begin
      logic              w, r1, r2;
      logic [ADDR_W-1:0] wa, a1, a2;
      logic [DATA_W-1:0] wd;
      w  = 1'($urandom_range(0, 1));
      wa = ADDR_W'($urandom_range(0, 7));
      wd = $urandom;
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 3) != 0);
      a1 = ADDR_W'($urandom_range(0, 7));
      a2 = ADDR_W'($urandom_range(0, 7));
      @(posedge clk); #1;
      drive(w, wa, wd, r1, a1, r2, a2);
      expect_rd("rand", model_rd(r1, a1), model_rd(r2, a2));
      #3;
      sample();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
